// File: rtl/breath_chase_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | breath_chase_ctrl_pkg                                                    |
// | Shared state encodings, LED polarity and width helpers for the breathing |
// | LED scheduler.                                                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package breath_chase_ctrl_pkg;

  localparam int c_st_w = 3;

  localparam logic [c_st_w-1:0] c_st_idle    = 3'd0;
  localparam logic [c_st_w-1:0] c_st_up      = 3'd1;
  localparam logic [c_st_w-1:0] c_st_hold_hi = 3'd2;
  localparam logic [c_st_w-1:0] c_st_down    = 3'd3;
  localparam logic [c_st_w-1:0] c_st_hold_lo = 3'd4;
  localparam logic [c_st_w-1:0] c_st_next    = 3'd5;

  localparam logic c_led_on  = 1'b0;
  localparam logic c_led_off = 1'b1;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int f_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // States in which the PWM counter runs and the selected LED is driven.
  function automatic logic f_st_active(input logic [c_st_w-1:0] st);
    return (st == c_st_up) || (st == c_st_hold_hi) ||
           (st == c_st_down) || (st == c_st_hold_lo);
  endfunction

endpackage
`default_nettype wire

// File: rtl/breath_chase_ctrl_pwm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | breath_chase_ctrl_pwm                                                    |
// | Shared PWM period counter and duty compare for the breathing scheduler.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module breath_chase_ctrl_pwm
  import breath_chase_ctrl_pkg::*;
#(
  parameter int PWM_MAX = 10000,
  parameter int DUTY_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [DUTY_W-1:0] duty,
  output logic              period_end,
  output logic              lit
);

  localparam int c_cnt_w = f_w(PWM_MAX);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(PWM_MAX - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last  = (r_cnt == c_cnt_last);
  assign period_end = run && w_at_last;
  assign lit        = (DUTY_W'(r_cnt) < duty);

  // Counter is parked at zero whenever not running so a fresh breath
  // always starts on a period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run || w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/breath_chase_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | breath_chase_ctrl                                                        |
// | Sequences one enabled LED channel at a time through a PWM breath         |
// | (ramp up / hold / ramp down / hold), then chases or repeats.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module breath_chase_ctrl
  import breath_chase_ctrl_pkg::*;
#(
  parameter int LED_NUM      = 8,
  parameter int PWM_MAX      = 10000,
  parameter int HOLD_PERIODS = 100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       chase,
  input  logic [LED_NUM-1:0]         led_en,
  output logic [LED_NUM-1:0]         led,
  output logic                       busy,
  output logic [$clog2(LED_NUM)-1:0] ch_idx,
  output logic                       cycle_done
);

  localparam int c_ch_w   = $clog2(LED_NUM);
  localparam int c_duty_w = f_w(PWM_MAX + 1);
  localparam int c_hold_w = f_w(HOLD_PERIODS + 1);

  localparam logic [c_duty_w-1:0] c_duty_one    = c_duty_w'(1);
  localparam logic [c_duty_w-1:0] c_duty_top_m1 = c_duty_w'(PWM_MAX - 1);
  localparam logic [c_hold_w-1:0] c_hold_last   = c_hold_w'(HOLD_PERIODS - 1);

  logic [c_st_w-1:0]   r_state;
  logic [c_st_w-1:0]   w_state_nxt;
  logic [c_duty_w-1:0] r_duty;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [c_ch_w-1:0]   r_ch_idx;
  logic [LED_NUM-1:0]  r_led;
  logic [LED_NUM-1:0]  w_led_nxt;
  logic [c_ch_w-1:0]   w_start_ch;
  logic [c_ch_w-1:0]   w_next_ch;
  logic                w_any_en;
  logic                w_pwm_run;
  logic                w_period_end;
  logic                w_lit;
  logic                w_up_done;
  logic                w_down_done;
  logic                w_hold_done;

  function automatic logic [c_ch_w-1:0] f_lowest(input logic [LED_NUM-1:0] mask);
    logic [c_ch_w-1:0] sel;
    sel = '0;
    for (int i = LED_NUM - 1; i >= 0; i--) begin
      if (mask[i]) sel = c_ch_w'(i);
    end
    return sel;
  endfunction

  // Circular search starting just above cur; scanning downward lets the
  // nearest set bit win. Offset LED_NUM lands back on cur itself.
  function automatic logic [c_ch_w-1:0] f_next(input logic [LED_NUM-1:0] mask,
                                               input logic [c_ch_w-1:0]  cur);
    logic [c_ch_w-1:0] sel;
    int                j;
    sel = cur;
    for (int i = LED_NUM; i >= 1; i--) begin
      j = int'(cur) + i;
      if (j >= LED_NUM) j = j - LED_NUM;
      if (mask[j]) sel = c_ch_w'(j);
    end
    return sel;
  endfunction

  assign w_any_en    = |led_en;
  assign w_start_ch  = f_lowest(led_en);
  assign w_next_ch   = chase ? f_next(led_en, r_ch_idx)
                             : (led_en[r_ch_idx] ? r_ch_idx : f_lowest(led_en));
  assign w_up_done   = (r_duty == c_duty_top_m1);
  assign w_down_done = (r_duty == c_duty_one);
  assign w_hold_done = (r_hold_cnt == c_hold_last);

  breath_chase_ctrl_pwm #(
    .PWM_MAX (PWM_MAX),
    .DUTY_W  (c_duty_w)
  ) u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (w_pwm_run),
    .duty       (r_duty),
    .period_end (w_period_end),
    .lit        (w_lit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:    if (start && w_any_en)          w_state_nxt = c_st_up;
        c_st_up:      if (w_period_end && w_up_done)   w_state_nxt = c_st_hold_hi;
        c_st_hold_hi: if (w_period_end && w_hold_done) w_state_nxt = c_st_down;
        c_st_down:    if (w_period_end && w_down_done) w_state_nxt = c_st_hold_lo;
        c_st_hold_lo: if (w_period_end && w_hold_done) w_state_nxt = c_st_next;
        c_st_next:    w_state_nxt = w_any_en ? c_st_up : c_st_idle;
        default:      w_state_nxt = c_st_idle;
      endcase
    end
  end

  always_comb begin
    busy       = (r_state != c_st_idle);
    cycle_done = (r_state == c_st_next);
    w_pwm_run  = f_st_active(r_state) && !stop;
    w_led_nxt  = {LED_NUM{c_led_off}};
    if (w_pwm_run) begin
      w_led_nxt[r_ch_idx] = w_lit ? c_led_on : c_led_off;
    end
  end

  // Duty and hold counters only move on period ends, so the compare never
  // sees a new duty in the middle of a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty     <= '0;
      r_hold_cnt <= '0;
      r_ch_idx   <= '0;
      r_led      <= {LED_NUM{c_led_off}};
    end else begin
      r_led <= w_led_nxt;
      if (stop) begin
        r_duty     <= '0;
        r_hold_cnt <= '0;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (start && w_any_en) begin
              r_ch_idx <= w_start_ch;
              r_duty   <= '0;
            end
          end
          c_st_up: begin
            if (w_period_end) begin
              r_duty     <= r_duty + c_duty_one;
              r_hold_cnt <= '0;
            end
          end
          c_st_hold_hi, c_st_hold_lo: begin
            if (w_period_end) r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
          end
          c_st_down: begin
            if (w_period_end) begin
              r_duty     <= r_duty - c_duty_one;
              r_hold_cnt <= '0;
            end
          end
          c_st_next: begin
            r_hold_cnt <= '0;
            r_duty     <= '0;
            if (w_any_en) r_ch_idx <= w_next_ch;
          end
          default: ;
        endcase
      end
    end
  end

  assign led    = r_led;
  assign ch_idx = r_ch_idx;

endmodule
`default_nettype wire
